// File: rtl/obi_apb_bridge_pkg.sv
// Shared types and constants for the OBI-to-APB bridge.
package obi_apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Read data returned on a timeout abort is this bit replicated across the bus.
  localparam logic TIMEOUT_FILL_BIT = 1'b1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 256;

endpackage

// File: rtl/obi_to_apb_bridge.sv
// Single-outstanding OBI subordinate to APB manager bridge with ACCESS timeout.
//
// state  | meaning
// IDLE   | waiting for an OBI request; the only state that grants
// SETUP  | APB setup phase: psel=1, penable=0
// ACCESS | APB access phase: psel=1, penable=1, waiting on pready or timeout
// RESP   | one-cycle OBI response (rvalid, err), APB bus idle
module obi_to_apb_bridge
  import obi_apb_bridge_pkg::*;
#(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   obi_req_i,
  output logic                   obi_gnt_o,
  input  logic [AddrWidth-1:0]   obi_addr_i,
  input  logic                   obi_we_i,
  input  logic [DataWidth/8-1:0] obi_be_i,
  input  logic [DataWidth-1:0]   obi_wdata_i,
  output logic                   obi_rvalid_o,
  output logic [DataWidth-1:0]   obi_rdata_o,
  output logic [AddrWidth-1:0]   apb_paddr_o,
  output logic [2:0]             apb_pprot_o,
  output logic                   apb_psel_o,
  output logic                   apb_penable_o,
  output logic                   apb_pwrite_o,
  output logic [DataWidth-1:0]   apb_pwdata_o,
  output logic [DataWidth/8-1:0] apb_pstrb_o,
  input  logic                   apb_pready_i,
  input  logic [DataWidth-1:0]   apb_prdata_i,
  input  logic                   apb_pslverr_i,
  output logic                   err_o
);

  localparam int StrbWidth = DataWidth / 8;
  // A zero-width counter is illegal, so keep one bit when the timeout is disabled.
  localparam int CntWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);

  state_e                 r_state;
  logic [AddrWidth-1:0]   r_paddr;
  logic                   r_pwrite;
  logic [DataWidth-1:0]   r_pwdata;
  logic [StrbWidth-1:0]   r_pstrb;
  logic                   r_psel;
  logic                   r_penable;
  logic [DataWidth-1:0]   r_rdata;
  logic                   r_rvalid;
  logic                   r_err;
  logic [CntWidth-1:0]    r_cnt;

  logic                   w_gnt;
  logic                   w_timeout;

  // Grant is purely combinational so a request in IDLE is accepted the same cycle.
  assign w_gnt     = obi_req_i && (r_state == IDLE);
  // Counter holds the number of ACCESS cycles already spent before this one.
  assign w_timeout = (TimeoutCycles > 0) && (r_cnt == CntLast);

  // Bridge FSM with all APB and OBI response outputs registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_paddr   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_rdata   <= '0;
      r_rvalid  <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_gnt) begin
            r_paddr  <= obi_addr_i;
            r_pwrite <= obi_we_i;
            r_pwdata <= obi_wdata_i;
            r_pstrb  <= obi_we_i ? obi_be_i : '0;
            r_psel   <= 1'b1;
            r_cnt    <= '0;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (apb_pready_i) begin
            r_rdata   <= r_pwrite ? '0 : apb_prdata_i;
            r_err     <= apb_pslverr_i;
            r_rvalid  <= 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= RESP;
          end else if (w_timeout) begin
            r_rdata   <= {DataWidth{TIMEOUT_FILL_BIT}};
            r_err     <= 1'b1;
            r_rvalid  <= 1'b1;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= RESP;
          end else begin
            r_cnt <= r_cnt + CntWidth'(1);
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign obi_gnt_o     = w_gnt;
  assign obi_rvalid_o  = r_rvalid;
  assign obi_rdata_o   = r_rdata;
  assign err_o         = r_err;
  assign apb_paddr_o   = r_paddr;
  assign apb_pprot_o   = 3'b000;
  assign apb_psel_o    = r_psel;
  assign apb_penable_o = r_penable;
  assign apb_pwrite_o  = r_pwrite;
  assign apb_pwdata_o  = r_pwdata;
  assign apb_pstrb_o   = r_pstrb;

endmodule

// File: tb/tb_obi_to_apb_bridge.sv
// Directed bench for obi_to_apb_bridge, built with a 4-cycle ACCESS timeout.
module tb_obi_to_apb_bridge;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic [31:0] apb_paddr_o;
  logic [2:0]  apb_pprot_o;
  logic        apb_psel_o;
  logic        apb_penable_o;
  logic        apb_pwrite_o;
  logic [31:0] apb_pwdata_o;
  logic [3:0]  apb_pstrb_o;
  logic        apb_pready_i;
  logic [31:0] apb_prdata_i;
  logic        apb_pslverr_i;
  logic        err_o;

  int checks = 0;
  int errors = 0;
  int grants = 0;

  obi_to_apb_bridge #(
    .AddrWidth    (32),
    .DataWidth    (32),
    .TimeoutCycles(4)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rdata_o  (obi_rdata_o),
    .apb_paddr_o  (apb_paddr_o),
    .apb_pprot_o  (apb_pprot_o),
    .apb_psel_o   (apb_psel_o),
    .apb_penable_o(apb_penable_o),
    .apb_pwrite_o (apb_pwrite_o),
    .apb_pwdata_o (apb_pwdata_o),
    .apb_pstrb_o  (apb_pstrb_o),
    .apb_pready_i (apb_pready_i),
    .apb_prdata_i (apb_prdata_i),
    .apb_pslverr_i(apb_pslverr_i),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs driven and outputs sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i         = 1'b1;
    obi_req_i     = 1'b0;
    obi_addr_i    = '0;
    obi_we_i      = 1'b0;
    obi_be_i      = '0;
    obi_wdata_i   = '0;
    apb_pready_i  = 1'b0;
    apb_prdata_i  = '0;
    apb_pslverr_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    #1;
    chk("rst_psel", 32'(apb_psel_o), 32'd0);
    chk("rst_penable", 32'(apb_penable_o), 32'd0);
    chk("rst_rvalid", 32'(obi_rvalid_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_paddr", apb_paddr_o, 32'd0);
    chk("rst_pstrb", 32'(apb_pstrb_o), 32'd0);
    chk("rst_rdata", obi_rdata_o, 32'd0);
    chk("rst_pprot", 32'(apb_pprot_o), 32'd0);
    chk("rst_gnt", 32'(obi_gnt_o), 32'd0);

    // Zero-wait write; pready already high during SETUP must be ignored.
    obi_req_i    = 1'b1;
    obi_addr_i   = 32'h1000_0004;
    obi_we_i     = 1'b1;
    obi_be_i     = 4'hF;
    obi_wdata_i  = 32'hA5A5_5A5A;
    apb_pready_i = 1'b1;
    #1;
    chk("wr_gnt", 32'(obi_gnt_o), 32'd1);
    tick();
    obi_req_i = 1'b0;
    #1;
    chk("wr_c1_psel", 32'(apb_psel_o), 32'd1);
    chk("wr_c1_penable", 32'(apb_penable_o), 32'd0);
    chk("wr_c1_paddr", apb_paddr_o, 32'h1000_0004);
    chk("wr_c1_pwrite", 32'(apb_pwrite_o), 32'd1);
    chk("wr_c1_pwdata", apb_pwdata_o, 32'hA5A5_5A5A);
    chk("wr_c1_pstrb", 32'(apb_pstrb_o), 32'hF);
    chk("wr_c1_rvalid", 32'(obi_rvalid_o), 32'd0);
    tick();
    chk("wr_c2_psel", 32'(apb_psel_o), 32'd1);
    chk("wr_c2_penable", 32'(apb_penable_o), 32'd1);
    chk("wr_c2_paddr", apb_paddr_o, 32'h1000_0004);
    chk("wr_c2_rvalid", 32'(obi_rvalid_o), 32'd0);
    tick();
    chk("wr_c3_rvalid", 32'(obi_rvalid_o), 32'd1);
    chk("wr_c3_err", 32'(err_o), 32'd0);
    chk("wr_c3_psel", 32'(apb_psel_o), 32'd0);
    chk("wr_c3_penable", 32'(apb_penable_o), 32'd0);
    chk("wr_c3_rdata", obi_rdata_o, 32'd0);
    tick();
    chk("wr_c4_rvalid", 32'(obi_rvalid_o), 32'd0);

    // Read with two wait states: pready first seen in the third ACCESS cycle.
    apb_pready_i = 1'b0;
    obi_req_i    = 1'b1;
    obi_addr_i   = 32'h2000_0010;
    obi_we_i     = 1'b0;
    obi_be_i     = 4'hF;
    obi_wdata_i  = 32'h0;
    #1;
    chk("rd_gnt", 32'(obi_gnt_o), 32'd1);
    tick();
    obi_req_i = 1'b0;
    #1;
    chk("rd_setup_pstrb", 32'(apb_pstrb_o), 32'h0);
    chk("rd_setup_pwrite", 32'(apb_pwrite_o), 32'd0);
    chk("rd_setup_paddr", apb_paddr_o, 32'h2000_0010);
    tick();
    chk("rd_acc1_penable", 32'(apb_penable_o), 32'd1);
    tick();
    chk("rd_acc2_penable", 32'(apb_penable_o), 32'd1);
    chk("rd_acc2_rvalid", 32'(obi_rvalid_o), 32'd0);
    tick();
    apb_pready_i = 1'b1;
    apb_prdata_i = 32'h1234_5678;
    #1;
    chk("rd_acc3_psel", 32'(apb_psel_o), 32'd1);
    chk("rd_acc3_pstrb", 32'(apb_pstrb_o), 32'h0);
    tick();
    apb_pready_i = 1'b0;
    apb_prdata_i = 32'h0;
    #1;
    chk("rd_resp_rvalid", 32'(obi_rvalid_o), 32'd1);
    chk("rd_resp_rdata", obi_rdata_o, 32'h1234_5678);
    chk("rd_resp_err", 32'(err_o), 32'd0);
    tick();
    chk("rd_idle_rvalid", 32'(obi_rvalid_o), 32'd0);
    chk("rd_idle_rdata_hold", obi_rdata_o, 32'h1234_5678);

    // Slave error on a zero-wait write.
    obi_req_i     = 1'b1;
    obi_addr_i    = 32'h3000_0000;
    obi_we_i      = 1'b1;
    obi_be_i      = 4'h3;
    obi_wdata_i   = 32'hDEAD_BEEF;
    apb_pready_i  = 1'b1;
    apb_pslverr_i = 1'b1;
    #1;
    chk("se_gnt", 32'(obi_gnt_o), 32'd1);
    tick();
    obi_req_i = 1'b0;
    #1;
    chk("se_pstrb", 32'(apb_pstrb_o), 32'h3);
    chk("se_rvalid_setup", 32'(obi_rvalid_o), 32'd0);
    tick();
    chk("se_acc_err", 32'(err_o), 32'd0);
    tick();
    chk("se_resp_rvalid", 32'(obi_rvalid_o), 32'd1);
    chk("se_resp_err", 32'(err_o), 32'd1);
    chk("se_resp_rdata", obi_rdata_o, 32'd0);
    apb_pslverr_i = 1'b0;
    apb_pready_i  = 1'b0;
    tick();
    chk("se_idle_err", 32'(err_o), 32'd0);
    chk("se_idle_rvalid", 32'(obi_rvalid_o), 32'd0);

    // Timeout: pready never rises, abort after four ACCESS cycles.
    obi_req_i  = 1'b1;
    obi_addr_i = 32'h4000_0000;
    obi_we_i   = 1'b0;
    #1;
    chk("to_gnt", 32'(obi_gnt_o), 32'd1);
    tick();
    obi_req_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("to_acc%0d_psel", k + 1), 32'(apb_psel_o), 32'd1);
      chk($sformatf("to_acc%0d_penable", k + 1), 32'(apb_penable_o), 32'd1);
      chk($sformatf("to_acc%0d_rvalid", k + 1), 32'(obi_rvalid_o), 32'd0);
    end
    tick();
    chk("to_resp_psel", 32'(apb_psel_o), 32'd0);
    chk("to_resp_penable", 32'(apb_penable_o), 32'd0);
    chk("to_resp_rvalid", 32'(obi_rvalid_o), 32'd1);
    chk("to_resp_err", 32'(err_o), 32'd1);
    chk("to_resp_rdata", obi_rdata_o, 32'hFFFF_FFFF);
    tick();
    chk("to_idle_rvalid", 32'(obi_rvalid_o), 32'd0);
    chk("to_idle_rdata_hold", obi_rdata_o, 32'hFFFF_FFFF);

    // Back-to-back: request held high, zero-wait reads.
    obi_req_i    = 1'b1;
    obi_addr_i   = 32'h0000_0100;
    obi_we_i     = 1'b0;
    apb_pready_i = 1'b1;
    apb_prdata_i = 32'hCAFE_0001;
    grants       = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (obi_gnt_o === 1'b1) grants++;
      chk($sformatf("b2b_gnt_c%0d", i), 32'(obi_gnt_o), (i % 4 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("b2b_rvalid_c%0d", i), 32'(obi_rvalid_o), (i % 4 == 3) ? 32'd1 : 32'd0);
      tick();
    end
    obi_req_i    = 1'b0;
    apb_pready_i = 1'b0;
    chk("b2b_grant_count", 32'(grants), 32'd3);
    chk("b2b_rdata", obi_rdata_o, 32'hCAFE_0001);

    // Reset asserted for one cycle while in ACCESS.
    obi_req_i   = 1'b1;
    obi_addr_i  = 32'h5000_0000;
    obi_we_i    = 1'b1;
    obi_be_i    = 4'hC;
    obi_wdata_i = 32'h0BAD_F00D;
    #1;
    chk("rs_gnt", 32'(obi_gnt_o), 32'd1);
    tick();
    obi_req_i = 1'b0;
    tick();
    chk("rs_acc_penable", 32'(apb_penable_o), 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("rs_psel", 32'(apb_psel_o), 32'd0);
    chk("rs_penable", 32'(apb_penable_o), 32'd0);
    chk("rs_rvalid", 32'(obi_rvalid_o), 32'd0);
    chk("rs_paddr", apb_paddr_o, 32'd0);
    chk("rs_pstrb", 32'(apb_pstrb_o), 32'd0);
    apb_pready_i = 1'b1;
    tick();
    chk("rs_after_rvalid", 32'(obi_rvalid_o), 32'd0);
    chk("rs_after_psel", 32'(apb_psel_o), 32'd0);
    obi_req_i   = 1'b1;
    obi_addr_i  = 32'h6000_0008;
    obi_we_i    = 1'b1;
    obi_be_i    = 4'h5;
    obi_wdata_i = 32'h1111_2222;
    #1;
    chk("rs_next_gnt", 32'(obi_gnt_o), 32'd1);
    tick();
    obi_req_i = 1'b0;
    #1;
    chk("rs_next_psel", 32'(apb_psel_o), 32'd1);
    chk("rs_next_paddr", apb_paddr_o, 32'h6000_0008);
    chk("rs_next_pstrb", 32'(apb_pstrb_o), 32'h5);
    tick();
    chk("rs_next_penable", 32'(apb_penable_o), 32'd1);
    tick();
    chk("rs_next_rvalid", 32'(obi_rvalid_o), 32'd1);
    chk("rs_next_err", 32'(err_o), 32'd0);
    apb_pready_i = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/obi_to_apb_bridge.md
OBI_TO_APB_BRIDGE -- requirements
Module: obi_to_apb_bridge

Interface
REQ-001 SHALL have parameter AddrWidth, default 32: width of OBI and APB address.
REQ-002 SHALL have parameter DataWidth, default 32: width of OBI and APB data; DataWidth/8 strobe bits.
REQ-003 SHALL have parameter TimeoutCycles, default 256: maximum ACCESS cycles allowed before abort; 0 disables the timeout.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk_i, input, 1: clock, all logic on its rising edge.
REQ-006 SHALL have port rst_i, input, 1: synchronous active-high reset.
REQ-007 SHALL have OBI subordinate ports obi_req_i (in, 1), obi_gnt_o (out, 1), obi_addr_i (in, AddrWidth), obi_we_i (in, 1), obi_be_i (in, DataWidth/8), obi_wdata_i (in, DataWidth).
REQ-008 SHALL have OBI response ports obi_rvalid_o (out, 1), obi_rdata_o (out, DataWidth).
REQ-009 SHALL have APB manager ports apb_paddr_o (out, AddrWidth), apb_pprot_o (out, 3), apb_psel_o (out, 1), apb_penable_o (out, 1), apb_pwrite_o (out, 1), apb_pwdata_o (out, DataWidth), apb_pstrb_o (out, DataWidth/8).
REQ-010 SHALL have APB inputs apb_pready_i (in, 1), apb_prdata_i (in, DataWidth), apb_pslverr_i (in, 1).
REQ-011 SHALL have port err_o, out, 1: one-cycle error pulse, coincident with obi_rvalid_o.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; reset state IDLE.
REQ-013 SHALL drive obi_gnt_o = obi_req_i AND state==IDLE (combinational); no grant outside IDLE.
REQ-014 SHALL on grant register addr, we, be, wdata and move IDLE->SETUP; exactly one transaction outstanding.
REQ-015 SHALL in SETUP drive psel=1, penable=0, then move unconditionally to ACCESS; pready in SETUP ignored.
REQ-016 SHALL in ACCESS drive psel=1, penable=1; paddr/pwrite/pwdata/pstrb held stable from SETUP through ACCESS.
REQ-017 SHALL drive pstrb = latched be for writes and all-zero for reads; pprot = 3'b000 always.
REQ-018 SHALL on pready=1 in ACCESS capture prdata into obi_rdata_o for reads (zero for writes), capture pslverr, and move to RESP.
REQ-019 SHALL in RESP assert obi_rvalid_o for exactly one cycle, err_o = captured pslverr, then return to IDLE.
REQ-020 SHALL count ACCESS cycles in a counter of width $clog2(TimeoutCycles+1); cleared on entering SETUP.
REQ-021 SHALL, when TimeoutCycles>0 and the counter reaches TimeoutCycles-1 without pready, deassert psel/penable next cycle, load obi_rdata_o with all-ones, set err_o, and enter RESP.
REQ-022 SHALL give latency grant->rvalid of 3 cycles with zero-wait APB; minimum 4 cycles between successive grants.
REQ-023 SHALL hold obi_rdata_o stable after RESP until the next capture.
REQ-024 SHALL drive psel=0, penable=0 in IDLE and RESP.

Reset
REQ-025 SHALL, when rst_i is high at a clock edge, go to IDLE and clear all registered outputs (paddr, pwrite, pwdata, pstrb, rdata, rvalid, err, counter) to zero.
REQ-026 SHALL, on reset mid-transfer, drop the transfer without obi_rvalid_o; psel and penable are 0 from the following cycle.

Structure
REQ-027 SHALL place the state enum, the timeout-abort data pattern and the default TimeoutCycles in package obi_apb_bridge_pkg.
REQ-028 SHALL be a single module; no sub-module, timeout counter inline.

Verification
REQ-029 SHALL cover zero-wait write: addr 0x1000_0004, wdata 0xA5A5_5A5A, be 0xF -> psel at cycle 1, penable at cycle 2, pstrb 0xF, rvalid at cycle 3, err_o 0.
REQ-030 SHALL cover read with 2 wait states: prdata 0x1234_5678, pready at 3rd ACCESS cycle -> rdata 0x1234_5678 with rvalid one cycle later, pstrb 0x0.
REQ-031 SHALL cover slave error: write with pslverr=1 at pready -> rvalid and err_o high in the same cycle.
REQ-032 SHALL cover timeout with TimeoutCycles=4, pready held 0 -> psel drops after 4 ACCESS cycles, rdata 0xFFFF_FFFF, err_o 1.
REQ-033 SHALL cover back-to-back: req held high continuously -> gnt only in IDLE, once per 4 cycles; no second grant while busy.
REQ-034 SHALL cover reset in ACCESS: rst_i high for one cycle -> psel=0 next cycle, no rvalid, next req granted normally.
